// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} = a + b + c_in.
// Latency: exactly 1 cycle from in_valid to out_valid; one operation per cycle.
// Backpressure: none; every qualified input is accepted and produces one result.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_nxt;
  logic             carry_nxt;
  logic             rip;

  // Ripple chain: per-bit full-adder equations, carry walking from LSB to MSB.
  // The running carry is a blocking temporary so the chain stays one flat cone.
  always_comb begin
    sum_nxt = '0;
    rip     = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_nxt[i] = a[i] ^ b[i] ^ rip;
      rip        = (a[i] & b[i]) | (a[i] & rip) | (b[i] & rip);
    end
    carry_nxt = rip;
  end

  // Output registers: load on in_valid, hold otherwise; valid is a one-cycle echo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_nxt;
        carry <= carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=8 with a per-instance result queue.
// Expected {carry,sum} is queued when an operand set is driven, checked on out_valid.
// Directed truth table, async reset, hold behaviour, wrap cases, then random vectors.
module tb_full_adder;

  logic       clk;
  logic       rst_n;

  logic       v1;
  logic [0:0] a1, b1;
  logic       c1;
  logic [0:0] sum1;
  logic       carry1, ov1;

  logic       v8;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] sum8;
  logic       carry8, ov8;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q1[$];
  logic [63:0] q8[$];

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c_in(c8),
    .sum(sum8), .carry(carry8), .out_valid(ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every out_valid pops one queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1) begin
        if (q1.size() == 0) chk("w1_unexpected_vld", {63'd0, ov1}, 64'd0);
        else chk("w1_result", {62'd0, carry1, sum1}, q1.pop_front());
      end
      if (ov8) begin
        if (q8.size() == 0) chk("w8_unexpected_vld", {63'd0, ov8}, 64'd0);
        else chk("w8_result", {55'd0, carry8, sum8}, q8.pop_front());
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp);
    @(posedge clk);
    #1;
    a8 = a; b8 = b; c8 = c; v8 = 1'b1;
    q8.push_back({55'd0, exp});
  endtask

  logic [1:0] tt_exp [8];
  int         vcnt;
  logic [7:0] ra, rb;
  logic       rc;

  initial begin
    // {carry,sum} for {a,b,c_in} = 0..7
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst_n = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_sum1",   {63'd0, sum1},   64'd0);
    chk("rst_carry1", {63'd0, carry1}, 64'd0);
    chk("rst_vld1",   {63'd0, ov1},    64'd0);
    chk("rst_sum8",   {56'd0, sum8},   64'd0);
    chk("rst_carry8", {63'd0, carry8}, 64'd0);
    chk("rst_vld8",   {63'd0, ov8},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      a1 = i[2]; b1 = i[1]; c1 = i[0]; v1 = 1'b1;
      q1.push_back({62'd0, tt_exp[i]});
    end

    // Load 1+1+1, then reset between edges: outputs clear with no clock.
    @(posedge clk);
    #1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    chk("prerst_sum1",   {63'd0, sum1},   64'd1);
    chk("prerst_carry1", {63'd0, carry1}, 64'd1);
    chk("prerst_vld1",   {63'd0, ov1},    64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sum1",   {63'd0, sum1},   64'd0);
    chk("arst_carry1", {63'd0, carry1}, 64'd0);
    chk("arst_vld1",   {63'd0, ov1},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-cycle pulse 1+1+0, then idle with toggling inputs: result holds.
    @(posedge clk);
    #1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    q1.push_back(64'b10);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov1) vcnt++;
      chk("hold_sum1",   {63'd0, sum1},   64'd0);
      chk("hold_carry1", {63'd0, carry1}, 64'd1);
      @(posedge clk);
      #1;
      a1 = ~a1; b1 = (k % 2 == 0) ? 1'b0 : 1'b1; c1 = ~c1;
    end
    chk("hold_vld_pulses", 64'(vcnt), 64'd1);

    // WIDTH=8 wrap cases and back-to-back pair.
    drive8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drive8(8'hFF, 8'h00, 1'b1, 9'h100);
    drive8(8'h12, 8'h34, 1'b0, 9'h046);
    drive8(8'h80, 8'h80, 1'b0, 9'h100);

    // Random vectors, one per cycle.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
    end
    @(posedge clk);
    #1;
    v8 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("w1_queue_drained", 64'(q1.size()), 64'd0);
    chk("w8_queue_drained", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
